// File: rtl/medidor_frequencia.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of GATE_CICLOS clk cycles and publishes the count as 4 BCD digits.
module medidor_frequencia #(
    parameter int unsigned GATE_CICLOS = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilita,
    input  logic        sinal,
    output logic [15:0] freq_bcd,
    output logic        valido,
    output logic        estouro,
    output logic        medindo
);

    typedef enum logic [1:0] {OCIOSO, MEDINDO, PUBLICA} estado_t;

    localparam logic [31:0] GATE_FIM = 32'(GATE_CICLOS - 2);
    localparam logic [15:0] BCD_MAX  = 16'h9999;

    estado_t     estado, prox;
    logic        sync1, sync2, hist, borda;
    logic [31:0] gate;
    logic [15:0] contador, contador_inc, contador_pub;
    logic        flag, cheio;

    function automatic logic [3:0] dig_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic c1, c2, c3;
        c1 = (v[3:0] == 4'd9);
        c2 = c1 && (v[7:4] == 4'd9);
        c3 = c2 && (v[11:8] == 4'd9);
        return {c3 ? dig_inc(v[15:12]) : v[15:12],
                c2 ? dig_inc(v[11:8])  : v[11:8],
                c1 ? dig_inc(v[7:4])   : v[7:4],
                dig_inc(v[3:0])};
    endfunction

    assign borda        = sync2 & ~hist;
    assign cheio        = (contador == BCD_MAX);
    assign contador_inc = cheio ? contador : bcd_inc(contador);
    // Value including the edge seen in the current cycle (used while counting and at publication)
    assign contador_pub = borda ? contador_inc : contador;

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (habilita) prox = MEDINDO;
            MEDINDO: begin
                if (!habilita)              prox = OCIOSO;
                else if (gate == GATE_FIM)  prox = PUBLICA;
            end
            PUBLICA: prox = habilita ? MEDINDO : OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= OCIOSO;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            gate     <= '0;
            contador <= '0;
            flag     <= 1'b0;
            freq_bcd <= '0;
            valido   <= 1'b0;
            estouro  <= 1'b0;
            medindo  <= 1'b0;
        end else begin
            estado  <= prox;
            sync1   <= sinal;
            sync2   <= sync1;
            hist    <= sync2;
            valido  <= (estado == PUBLICA);
            medindo <= (prox != OCIOSO);

            // Window state clears by default; only an ongoing MEDINDO keeps it
            gate     <= '0;
            contador <= '0;
            flag     <= 1'b0;

            case (estado)
                MEDINDO: begin
                    if (habilita) begin
                        gate     <= gate + 32'd1;
                        contador <= contador_pub;
                        flag     <= flag | (borda & cheio);
                    end
                end
                PUBLICA: begin
                    freq_bcd <= contador_pub;
                    estouro  <= flag | (cheio & borda);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_medidor_frequencia.sv
// Self-checking bench for medidor_frequencia: a cycle-level reference model based on
// window position and a plain integer edge count, plus directed scenario checks.
module tb_medidor_frequencia;

    localparam int G     = 100;
    localparam int G_EST = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, habilita, sinal;
    logic [15:0] freq_bcd;
    logic        valido, estouro, medindo;

    logic        rst2, habilita2, sinal2;
    logic [15:0] freq_bcd2;
    logic        valido2, estouro2, medindo2;

    medidor_frequencia #(.GATE_CICLOS(G)) dut (
        .clk(clk), .rst(rst), .habilita(habilita), .sinal(sinal),
        .freq_bcd(freq_bcd), .valido(valido), .estouro(estouro), .medindo(medindo)
    );

    medidor_frequencia #(.GATE_CICLOS(G_EST)) dut_est (
        .clk(clk), .rst(rst2), .habilita(habilita2), .sinal(sinal2),
        .freq_bcd(freq_bcd2), .valido(valido2), .estouro(estouro2), .medindo(medindo2)
    );

    int n_testes = 0;
    int n_falhas = 0;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_testes++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        int m;
        m = (n > 9999) ? 9999 : n;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Reference model: position inside the window (-1 = idle, G-1 = publish cycle)
    int          fase_m = -1;
    int          ev = 0;
    bit          b_m;
    bit          amostra[$] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] exp_freq = '0;
    bit          exp_val = 1'b0, exp_est = 1'b0, exp_med = 1'b0;
    bit          checking = 1'b0;

    always @(posedge clk) begin
        b_m = amostra[1] && !amostra[2];
        if (rst) begin
            fase_m = -1; ev = 0;
            exp_freq = '0; exp_val = 1'b0; exp_est = 1'b0; exp_med = 1'b0;
            amostra = '{1'b0, 1'b0, 1'b0};
        end else begin
            exp_val = 1'b0;
            if (fase_m < 0) begin
                if (habilita) begin fase_m = 0; ev = 0; end
            end else if (fase_m < G - 1) begin
                if (!habilita) fase_m = -1;
                else begin ev += int'(b_m); fase_m++; end
            end else begin
                ev += int'(b_m);
                exp_freq = to_bcd(ev);
                exp_est  = (ev > 9999);
                exp_val  = 1'b1;
                ev       = 0;
                fase_m   = habilita ? 0 : -1;
            end
            exp_med = (fase_m >= 0);
            amostra.push_front(sinal);
            void'(amostra.pop_back());
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            verifica("ciclo_freq",    32'(freq_bcd), 32'(exp_freq));
            verifica("ciclo_valido",  32'(valido),   32'(exp_val));
            verifica("ciclo_estouro", 32'(estouro),  32'(exp_est));
            verifica("ciclo_medindo", 32'(medindo),  32'(exp_med));
        end
    end

    // Stimulus: 0 hold low, 1 hold high, 2 square period 10, 3 random, 4 toggle each cycle
    int modo = 4;
    int fase = 0;

    task automatic passo();
        @(negedge clk);
        fase++;
        case (modo)
            0: sinal = 1'b0;
            1: sinal = 1'b1;
            2: if (fase % 5 == 0) sinal = ~sinal;
            3: sinal = 1'($urandom);
            default: sinal = ~sinal;
        endcase
    endtask

    task automatic espera_medindo(input int limite);
        int n;
        n = 0;
        while (!medindo && n < limite) begin passo(); n++; end
        if (!medindo) verifica("timeout_medindo", 32'(medindo), 32'd1);
    endtask

    task automatic espera_valido(input int limite, output int n);
        n = 0;
        do begin passo(); n++; end while (!valido && n < limite);
        if (!valido) verifica("timeout_valido", 32'(valido), 32'd1);
    endtask

    initial begin
        rst = 1'b1; habilita = 1'b0; sinal = 1'b0;
        rst2 = 1'b1; habilita2 = 1'b0; sinal2 = 1'b0;
        @(posedge clk);
        #1 checking = 1'b1;
        fork
            begin : principal
                int n, nv;
                repeat (3) passo();
                verifica("reset_freq",    32'(freq_bcd), 32'h0);
                verifica("reset_valido",  32'(valido),   32'h0);
                verifica("reset_estouro", 32'(estouro),  32'h0);
                verifica("reset_medindo", 32'(medindo),  32'h0);

                rst = 1'b0; habilita = 1'b1; sinal = 1'b0; modo = 2; fase = 0;
                espera_medindo(5);
                espera_valido(300, n);
                verifica("quad_latencia1", 32'(n), 32'd100);
                verifica("quad_freq1",     32'(freq_bcd), 32'h0010);
                verifica("quad_estouro1",  32'(estouro),  32'h0);
                espera_valido(300, n);
                verifica("quad_latencia2", 32'(n), 32'd100);
                verifica("quad_freq2",     32'(freq_bcd), 32'h0010);

                repeat (50) passo();
                habilita = 1'b0;
                passo();
                verifica("aborto_medindo", 32'(medindo), 32'h0);
                nv = 0;
                repeat (150) begin passo(); if (valido) nv++; end
                verifica("aborto_sem_valido", 32'(nv), 32'd0);
                verifica("aborto_freq",       32'(freq_bcd), 32'h0010);
                habilita = 1'b1;
                espera_medindo(5);
                espera_valido(300, n);
                verifica("reinicio_latencia", 32'(n), 32'd100);

                modo = 0;
                espera_valido(300, n);
                espera_valido(300, n);
                verifica("dc0_freq",    32'(freq_bcd), 32'h0);
                verifica("dc0_estouro", 32'(estouro),  32'h0);

                habilita = 1'b0; modo = 1;
                repeat (10) passo();
                habilita = 1'b1;
                espera_medindo(5);
                espera_valido(300, n);
                verifica("dc1_freq", 32'(freq_bcd), 32'h0);

                modo = 2; fase = 0;
                espera_valido(300, n);
                repeat (59) passo();
                rst = 1'b1;
                passo();
                verifica("rstmeio_freq",    32'(freq_bcd), 32'h0);
                verifica("rstmeio_valido",  32'(valido),   32'h0);
                verifica("rstmeio_estouro", 32'(estouro),  32'h0);
                verifica("rstmeio_medindo", 32'(medindo),  32'h0);
                rst = 1'b0;
                espera_medindo(5);
                espera_valido(300, n);
                verifica("rstmeio_latencia", 32'(n), 32'd100);

                modo = 3;
                for (int i = 0; i < 3000; i++) begin
                    passo();
                    if ($urandom_range(0, 199) == 0) habilita = 1'b0;
                    else if (!habilita && $urandom_range(0, 3) == 0) habilita = 1'b1;
                    rst = ($urandom_range(0, 999) == 0);
                end
                rst = 1'b0; habilita = 1'b0;
                repeat (5) passo();
            end
            begin : teste_estouro
                int n;
                repeat (3) @(negedge clk);
                rst2 = 1'b0; habilita2 = 1'b1;
                for (int i = 0; i < 29000; i++) begin
                    @(negedge clk);
                    sinal2 = ~sinal2;
                end
                sinal2 = 1'b0;
                n = 0;
                while (!valido2 && n < 3000) begin @(negedge clk); n++; end
                verifica("est_valido",  32'(valido2),   32'd1);
                verifica("est_freq",    32'(freq_bcd2), 32'h9999);
                verifica("est_estouro", 32'(estouro2),  32'd1);
                @(negedge clk);
                verifica("est_pulso", 32'(valido2), 32'd0);
                n = 0;
                while (!valido2 && n < 31000) begin @(negedge clk); n++; end
                verifica("est_valido2",  32'(valido2),   32'd1);
                verifica("est_freq2",    32'(freq_bcd2), 32'h0);
                verifica("est_estouro2", 32'(estouro2),  32'd0);
                habilita2 = 1'b0;
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
